// File: rtl/wb_qspi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_qspi_arbiter
// Brief    : Round-robin ibus/dbus arbiter in front of one QSPI memory adapter,
//            ROM/RAM decode, dbus ROM-write rejection. Define WB_QSPI_ARB_IBUF_EN
//            for a single-entry instruction buffer.
// Revision : 1.0 - initial release
// ============================================================================
module wb_qspi_arbiter #(
    parameter int RAM_SEL_BIT = 24
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        ibus_stb_i,
    input  logic [31:0] ibus_adr_i,
    output logic        ibus_ack_o,
    output logic [31:0] ibus_dat_o,

    input  logic        dbus_stb_i,
    input  logic        dbus_we_i,
    input  logic [3:0]  dbus_be_i,
    input  logic [31:0] dbus_adr_i,
    input  logic [31:0] dbus_dat_i,
    output logic        dbus_ack_o,
    output logic        dbus_err_o,
    output logic [31:0] dbus_dat_o,

    output logic        mem_sel_rom_ram_o,
    output logic        mem_stb_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [21:0] mem_adr_o,
    output logic [31:0] mem_dat_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_dat_i
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GNT_I = 3'd1,
        S_GNT_D = 3'd2,
        S_ERR   = 3'd3
`ifdef WB_QSPI_ARB_IBUF_EN
        ,
        S_HIT   = 3'd4
`endif
    } state_t;

    localparam logic c_LAST_I = 1'b0;
    localparam logic c_LAST_D = 1'b1;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_last;
    logic   w_last_nxt;
    logic   w_d_wins;
    logic   w_i_wins;
    logic   w_d_rom_wr;
    logic   w_gnt_d;
    logic   w_unused;

    // On a tie the master that was not served last wins.
    assign w_d_wins   = dbus_stb_i && (!ibus_stb_i || (r_last == c_LAST_I));
    assign w_i_wins   = ibus_stb_i && !w_d_wins;
    assign w_d_rom_wr = dbus_we_i && !dbus_adr_i[RAM_SEL_BIT];
    assign w_gnt_d    = (r_state == S_GNT_D);

    assign w_unused = ^{ibus_adr_i, dbus_adr_i};

`ifdef WB_QSPI_ARB_IBUF_EN
    logic        r_ibuf_valid;
    logic [21:0] r_ibuf_tag;
    logic [31:0] r_ibuf_data;
    logic        w_ibuf_hit;
    logic        w_ibuf_fill;
    logic        w_ibuf_inval;

    assign w_ibuf_hit   = r_ibuf_valid && (r_ibuf_tag == ibus_adr_i[23:2]);
    assign w_ibuf_fill  = (r_state == S_GNT_I) && mem_ack_i;
    assign w_ibuf_inval = w_gnt_d && mem_ack_i && dbus_we_i && dbus_adr_i[RAM_SEL_BIT]
                          && (dbus_adr_i[23:2] == r_ibuf_tag);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ibuf_valid <= 1'b0;
        end else if (w_ibuf_fill) begin
            r_ibuf_valid <= 1'b1;
            r_ibuf_tag   <= ibus_adr_i[23:2];
            r_ibuf_data  <= mem_dat_i;
        end else if (w_ibuf_inval) begin
            r_ibuf_valid <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_last  <= c_LAST_I;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        ibus_ack_o  = 1'b0;
        dbus_ack_o  = 1'b0;
        dbus_err_o  = 1'b0;
        mem_stb_o   = 1'b0;
        ibus_dat_o  = mem_dat_i;

        case (r_state)
            S_IDLE: begin
                if (w_d_wins) begin
                    if (w_d_rom_wr) begin
                        w_state_nxt = S_ERR;
                    end else begin
                        w_state_nxt = S_GNT_D;
                        w_last_nxt  = c_LAST_D;
                    end
                end else if (w_i_wins) begin
`ifdef WB_QSPI_ARB_IBUF_EN
                    if (w_ibuf_hit) begin
                        w_state_nxt = S_HIT;
                    end else
`endif
                    begin
                        w_state_nxt = S_GNT_I;
                        w_last_nxt  = c_LAST_I;
                    end
                end
            end
            S_GNT_I: begin
                mem_stb_o = 1'b1;
                if (mem_ack_i) begin
                    ibus_ack_o  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_GNT_D: begin
                mem_stb_o = 1'b1;
                if (mem_ack_i) begin
                    dbus_ack_o  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_ERR: begin
                dbus_err_o  = 1'b1;
                w_state_nxt = S_IDLE;
            end
`ifdef WB_QSPI_ARB_IBUF_EN
            S_HIT: begin
                ibus_ack_o  = 1'b1;
                ibus_dat_o  = r_ibuf_data;
                w_state_nxt = S_IDLE;
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // A reset cycle aborts whatever the state register still holds.
        if (rst_i) begin
            ibus_ack_o = 1'b0;
            dbus_ack_o = 1'b0;
            dbus_err_o = 1'b0;
            mem_stb_o  = 1'b0;
        end
    end

    assign mem_sel_rom_ram_o = w_gnt_d ? dbus_adr_i[RAM_SEL_BIT] : ibus_adr_i[RAM_SEL_BIT];
    assign mem_we_o          = w_gnt_d && dbus_we_i;
    assign mem_be_o          = w_gnt_d ? dbus_be_i : 4'hF;
    assign mem_adr_o         = w_gnt_d ? dbus_adr_i[23:2] : ibus_adr_i[23:2];
    assign mem_dat_o         = dbus_dat_i;
    assign dbus_dat_o        = mem_dat_i;

endmodule
`default_nettype wire

// File: tb/tb_wb_qspi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_qspi_arbiter
// Brief    : Directed vector table plus randomized traffic against a
//            transaction-level reference model of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_qspi_arbiter;

    localparam int c_RAM_BIT = 24;

    logic        clk_i;
    logic        rst_i;
    logic        ibus_stb_i;
    logic [31:0] ibus_adr_i;
    logic        ibus_ack_o;
    logic [31:0] ibus_dat_o;
    logic        dbus_stb_i;
    logic        dbus_we_i;
    logic [3:0]  dbus_be_i;
    logic [31:0] dbus_adr_i;
    logic [31:0] dbus_dat_i;
    logic        dbus_ack_o;
    logic        dbus_err_o;
    logic [31:0] dbus_dat_o;
    logic        mem_sel_rom_ram_o;
    logic        mem_stb_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [21:0] mem_adr_o;
    logic [31:0] mem_dat_o;
    logic        mem_ack_i;
    logic [31:0] mem_dat_i;

    wb_qspi_arbiter #(.RAM_SEL_BIT(c_RAM_BIT)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .ibus_stb_i        (ibus_stb_i),
        .ibus_adr_i        (ibus_adr_i),
        .ibus_ack_o        (ibus_ack_o),
        .ibus_dat_o        (ibus_dat_o),
        .dbus_stb_i        (dbus_stb_i),
        .dbus_we_i         (dbus_we_i),
        .dbus_be_i         (dbus_be_i),
        .dbus_adr_i        (dbus_adr_i),
        .dbus_dat_i        (dbus_dat_i),
        .dbus_ack_o        (dbus_ack_o),
        .dbus_err_o        (dbus_err_o),
        .dbus_dat_o        (dbus_dat_o),
        .mem_sel_rom_ram_o (mem_sel_rom_ram_o),
        .mem_stb_o         (mem_stb_o),
        .mem_we_o          (mem_we_o),
        .mem_be_o          (mem_be_o),
        .mem_adr_o         (mem_adr_o),
        .mem_dat_o         (mem_dat_o),
        .mem_ack_i         (mem_ack_i),
        .mem_dat_i         (mem_dat_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    typedef struct {
        logic        rst;
        logic        istb;
        logic [31:0] iadr;
        logic        dstb;
        logic        dwe;
        logic [3:0]  dbe;
        logic [31:0] dadr;
        logic [31:0] ddat;
        logic        mack;
        logic [31:0] mdat;
        logic        e_stb;
        logic        e_sel;
        logic        e_we;
        logic [3:0]  e_be;
        logic [21:0] e_adr;
        logic        e_iack;
        logic        e_dack;
        logic        e_err;
        logic [31:0] e_dat;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: who is being served and what the buffer holds.
    // owner: 0 nobody, 1 ibus via adapter, 2 dbus via adapter, 3 rejected write, 4 buffer hit
    int          m_owner;
    bit          m_dprio;
    bit          m_buf_ok;
    logic [21:0] m_buf_word;
    logic [31:0] m_buf_data;

    bit          ir, dr, dw, r, mack, e_busy, e_iack, e_dack, e_err;
    logic [31:0] ia, da, dd, md;
    logic [3:0]  db;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic row(input logic [31:0] a_rst, a_istb, a_iadr, a_dstb, a_dwe, a_dbe,
                       a_dadr, a_ddat, a_mack, a_mdat, x_stb, x_sel, x_we, x_be,
                       x_adr, x_iack, x_dack, x_err, x_dat);
        vec_t v;
        v.rst = a_rst[0];   v.istb = a_istb[0]; v.iadr = a_iadr;
        v.dstb = a_dstb[0]; v.dwe = a_dwe[0];   v.dbe = a_dbe[3:0];
        v.dadr = a_dadr;    v.ddat = a_ddat;    v.mack = a_mack[0];
        v.mdat = a_mdat;    v.e_stb = x_stb[0]; v.e_sel = x_sel[0];
        v.e_we = x_we[0];   v.e_be = x_be[3:0]; v.e_adr = x_adr[21:0];
        v.e_iack = x_iack[0]; v.e_dack = x_dack[0]; v.e_err = x_err[0];
        v.e_dat = x_dat;
        tbl.push_back(v);
    endtask

    task automatic apply_row(input int idx, input vec_t v);
        rst_i      = v.rst;
        ibus_stb_i = v.istb;
        ibus_adr_i = v.iadr;
        dbus_stb_i = v.dstb;
        dbus_we_i  = v.dwe;
        dbus_be_i  = v.dbe;
        dbus_adr_i = v.dadr;
        dbus_dat_i = v.ddat;
        mem_ack_i  = v.mack;
        mem_dat_i  = v.mdat;
        #1;
        chk($sformatf("row%0d/mem_stb", idx), 32'(mem_stb_o), 32'(v.e_stb));
        chk($sformatf("row%0d/ibus_ack", idx), 32'(ibus_ack_o), 32'(v.e_iack));
        chk($sformatf("row%0d/dbus_ack", idx), 32'(dbus_ack_o), 32'(v.e_dack));
        chk($sformatf("row%0d/dbus_err", idx), 32'(dbus_err_o), 32'(v.e_err));
        if (v.e_stb) begin
            chk($sformatf("row%0d/mem_sel", idx), 32'(mem_sel_rom_ram_o), 32'(v.e_sel));
            chk($sformatf("row%0d/mem_we", idx), 32'(mem_we_o), 32'(v.e_we));
            chk($sformatf("row%0d/mem_be", idx), 32'(mem_be_o), 32'(v.e_be));
            chk($sformatf("row%0d/mem_adr", idx), 32'(mem_adr_o), 32'(v.e_adr));
        end
        if (v.e_stb && v.e_we)
            chk($sformatf("row%0d/mem_dat", idx), mem_dat_o, v.e_dat);
        else if (v.e_iack)
            chk($sformatf("row%0d/ibus_dat", idx), ibus_dat_o, v.e_dat);
        else if (v.e_dack)
            chk($sformatf("row%0d/dbus_dat", idx), dbus_dat_o, v.e_dat);
    endtask

    function automatic logic [31:0] rand_adr();
        logic [31:0] a;
        a       = $urandom;
        a[23:2] = 22'($urandom_range(0, 7));
        a[1:0]  = 2'b00;
        return a;
    endfunction

    initial begin
        // rst istb iadr dstb dwe dbe dadr ddat mack mdat | stb sel we be adr iack dack err dat
        row(1, 0,0, 0,0,'hF,0,0, 0,0,             0,0,0,'hF,0,    0,0,0,0);
        row(1, 0,0, 0,0,'hF,0,0, 0,0,             0,0,0,'hF,0,    0,0,0,0);
        // first tie after reset -> dbus, then alternate D,I,D,I
        row(0, 1,'h100, 1,0,'hF,'h0100_0020,0, 0,0,              0,0,0,'hF,0,    0,0,0,0);
        row(0, 1,'h100, 1,0,'hF,'h0100_0020,0, 1,'hA000_0001,    1,1,0,'hF,'h8,  0,1,0,'hA000_0001);
        row(0, 1,'h100, 1,0,'hF,'h0100_0020,0, 0,0,              0,0,0,'hF,0,    0,0,0,0);
        row(0, 1,'h100, 1,0,'hF,'h0100_0020,0, 1,'hA000_0002,    1,0,0,'hF,'h40, 1,0,0,'hA000_0002);
        row(0, 1,'h104, 1,0,'hF,'h0100_0024,0, 0,0,              0,0,0,'hF,0,    0,0,0,0);
        row(0, 1,'h104, 1,0,'hF,'h0100_0024,0, 1,'hA000_0003,    1,1,0,'hF,'h9,  0,1,0,'hA000_0003);
        row(0, 1,'h104, 1,0,'hF,'h0100_0024,0, 0,0,              0,0,0,'hF,0,    0,0,0,0);
        row(0, 1,'h104, 1,0,'hF,'h0100_0024,0, 1,'hA000_0004,    1,0,0,'hF,'h41, 1,0,0,'hA000_0004);
        row(0, 0,0, 0,0,'hF,0,0, 0,0,             0,0,0,'hF,0,    0,0,0,0);
        // ibus fetch 0x10 with one wait cycle
        row(0, 1,'h10, 0,0,'hF,0,0, 0,'h5555_5555,  1?0:0,0,0,'hF,0,    0,0,0,0);
        row(0, 1,'h10, 0,0,'hF,0,0, 0,'h5555_5555,  1,0,0,'hF,'h4,  0,0,0,0);
        row(0, 1,'h10, 0,0,'hF,0,0, 1,'h1234_5678,  1,0,0,'hF,'h4,  1,0,0,'h1234_5678);
        row(0, 0,0, 0,0,'hF,0,0, 0,0,             0,0,0,'hF,0,    0,0,0,0);
        // dbus write to ROM: one error cycle, no adapter strobe, round robin untouched
        row(0, 0,0, 1,1,'hF,'h4,'hCAFE_F00D, 0,0,   0,0,0,'hF,0,    0,0,0,0);
        row(0, 0,0, 1,1,'hF,'h4,'hCAFE_F00D, 0,0,   0,0,0,'hF,0,    0,0,1,0);
        row(0, 0,0, 0,0,'hF,0,0, 0,0,             0,0,0,'hF,0,    0,0,0,0);
        row(0, 1,'h200, 1,0,'hF,'h0100_0040,0, 0,0,              0,0,0,'hF,0,    0,0,0,0);
        row(0, 1,'h200, 1,0,'hF,'h0100_0040,0, 1,'hB000_0001,    1,1,0,'hF,'h10, 0,1,0,'hB000_0001);
        row(0, 1,'h200, 0,0,'hF,0,0, 0,0,         0,0,0,'hF,0,    0,0,0,0);
        row(0, 1,'h200, 0,0,'hF,0,0, 1,'hB000_0002, 1,0,0,'hF,'h80, 1,0,0,'hB000_0002);
        row(0, 0,0, 0,0,'hF,0,0, 0,0,             0,0,0,'hF,0,    0,0,0,0);
        // dbus sw to RAM, full word then partial
        row(0, 0,0, 1,1,'hF,'h0100_0008,'hDEAD_BEEF, 0,0,            0,0,0,'hF,0,    0,0,0,0);
        row(0, 0,0, 1,1,'hF,'h0100_0008,'hDEAD_BEEF, 0,0,            1,1,1,'hF,'h2,  0,0,0,'hDEAD_BEEF);
        row(0, 0,0, 1,1,'hF,'h0100_0008,'hDEAD_BEEF, 1,'h0BAD_0BAD,  1,1,1,'hF,'h2,  0,1,0,'hDEAD_BEEF);
        row(0, 0,0, 0,0,'hF,0,0, 0,0,             0,0,0,'hF,0,    0,0,0,0);
        row(0, 0,0, 1,1,'h3,'h0100_000C,'h0000_A5A5, 0,0,            0,0,0,'hF,0,    0,0,0,0);
        row(0, 0,0, 1,1,'h3,'h0100_000C,'h0000_A5A5, 1,0,            1,1,1,'h3,'h3,  0,1,0,'h0000_A5A5);
        row(0, 0,0, 0,0,'hF,0,0, 0,0,             0,0,0,'hF,0,    0,0,0,0);
        // dbus read from ROM is allowed
        row(0, 0,0, 1,0,'hF,'h30,0, 0,0,          0,0,0,'hF,0,    0,0,0,0);
        row(0, 0,0, 1,0,'hF,'h30,0, 1,'hC000_0000, 1,0,0,'hF,'hC, 0,1,0,'hC000_0000);
        row(0, 0,0, 0,0,'hF,0,0, 0,0,             0,0,0,'hF,0,    0,0,0,0);
        // reset while dbus is granted, adapter acks in the reset cycle
        row(0, 0,0, 1,0,'hF,'h0100_0100,0, 0,0,   0,0,0,'hF,0,    0,0,0,0);
        row(0, 0,0, 1,0,'hF,'h0100_0100,0, 0,0,   1,1,0,'hF,'h40, 0,0,0,0);
        row(1, 0,0, 1,0,'hF,'h0100_0100,0, 1,'hEEEE_EEEE, 0,0,0,'hF,0, 0,0,0,0);
        row(0, 0,0, 0,0,'hF,0,0, 0,0,             0,0,0,'hF,0,    0,0,0,0);
        row(0, 1,'h0100_0010, 0,0,'hF,0,0, 0,0,            0,0,0,'hF,0,    0,0,0,0);
        row(0, 1,'h0100_0010, 0,0,'hF,0,0, 0,0,            1,1,0,'hF,'h4,  0,0,0,0);
        row(0, 1,'h0100_0010, 0,0,'hF,0,0, 1,'hC000_0001,  1,1,0,'hF,'h4,  1,0,0,'hC000_0001);
        row(0, 0,0, 0,0,'hF,0,0, 0,0,             0,0,0,'hF,0,    0,0,0,0);
`ifdef WB_QSPI_ARB_IBUF_EN
        // fetch 0x40 twice: second served from the buffer one cycle after stb
        row(0, 1,'h40, 0,0,'hF,0,0, 0,0,          0,0,0,'hF,0,    0,0,0,0);
        row(0, 1,'h40, 0,0,'hF,0,0, 1,'hD000_0001, 1,0,0,'hF,'h10, 1,0,0,'hD000_0001);
        row(0, 0,0, 0,0,'hF,0,0, 0,0,             0,0,0,'hF,0,    0,0,0,0);
        row(0, 1,'h40, 0,0,'hF,0,0, 0,'h9999_9999, 0,0,0,'hF,0,   0,0,0,0);
        row(0, 1,'h40, 0,0,'hF,0,0, 0,'h9999_9999, 0,0,0,'hF,0,   1,0,0,'hD000_0001);
        row(0, 0,0, 0,0,'hF,0,0, 0,0,             0,0,0,'hF,0,    0,0,0,0);
        // RAM write to the buffered word forces the next fetch to the adapter
        row(0, 0,0, 1,1,'hF,'h0100_0040,'h7777_7777, 0,0,  0,0,0,'hF,0,    0,0,0,0);
        row(0, 0,0, 1,1,'hF,'h0100_0040,'h7777_7777, 1,0,  1,1,1,'hF,'h10, 0,1,0,'h7777_7777);
        row(0, 0,0, 0,0,'hF,0,0, 0,0,             0,0,0,'hF,0,    0,0,0,0);
        row(0, 1,'h40, 0,0,'hF,0,0, 0,0,          0,0,0,'hF,0,    0,0,0,0);
        row(0, 1,'h40, 0,0,'hF,0,0, 0,0,          1,0,0,'hF,'h10, 0,0,0,0);
        row(0, 1,'h40, 0,0,'hF,0,0, 1,'hD000_0002, 1,0,0,'hF,'h10, 1,0,0,'hD000_0002);
        row(0, 0,0, 0,0,'hF,0,0, 0,0,             0,0,0,'hF,0,    0,0,0,0);
`endif
        foreach (tbl[i]) begin
            @(negedge clk_i);
            apply_row(i, tbl[i]);
        end

        // Randomized traffic: two Wishbone-classic masters and a random-latency adapter.
        ir = 0; dr = 0; ia = 0; da = 0; dd = 0; dw = 0; db = 4'hF;
        m_owner = 0; m_dprio = 1; m_buf_ok = 0; m_buf_word = 0; m_buf_data = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk_i);
            r = (cyc < 2) || ($urandom_range(0, 299) == 0);
            if (r) begin
                ir = 0;
                dr = 0;
            end else begin
                if (!ir && $urandom_range(0, 2) == 0) begin
                    ir = 1;
                    ia = rand_adr();
                end
                if (!dr && $urandom_range(0, 2) == 0) begin
                    dr = 1;
                    da = rand_adr();
                    dw = 1'($urandom_range(0, 1));
                    db = 4'($urandom);
                    dd = $urandom;
                end
            end
            mack = (m_owner == 1 || m_owner == 2) && ($urandom_range(0, 2) == 0);
            md   = $urandom;

            rst_i      = r;
            ibus_stb_i = ir;
            ibus_adr_i = ia;
            dbus_stb_i = dr;
            dbus_we_i  = dw;
            dbus_be_i  = db;
            dbus_adr_i = da;
            dbus_dat_i = dd;
            mem_ack_i  = mack;
            mem_dat_i  = md;
            #1;

            e_busy = !r && (m_owner == 1 || m_owner == 2);
            e_iack = !r && ((m_owner == 1 && mack) || m_owner == 4);
            e_dack = !r && m_owner == 2 && mack;
            e_err  = !r && m_owner == 3;
            chk("rand/mem_stb", 32'(mem_stb_o), 32'(e_busy));
            chk("rand/ibus_ack", 32'(ibus_ack_o), 32'(e_iack));
            chk("rand/dbus_ack", 32'(dbus_ack_o), 32'(e_dack));
            chk("rand/dbus_err", 32'(dbus_err_o), 32'(e_err));
            if (e_busy && m_owner == 2) begin
                chk("rand/d_sel", 32'(mem_sel_rom_ram_o), 32'(da[c_RAM_BIT]));
                chk("rand/d_we", 32'(mem_we_o), 32'(dw));
                chk("rand/d_be", 32'(mem_be_o), 32'(db));
                chk("rand/d_adr", 32'(mem_adr_o), 32'(da[23:2]));
                if (dw) chk("rand/d_wdat", mem_dat_o, dd);
            end else if (e_busy) begin
                chk("rand/i_sel", 32'(mem_sel_rom_ram_o), 32'(ia[c_RAM_BIT]));
                chk("rand/i_we", 32'(mem_we_o), 32'(1'b0));
                chk("rand/i_be", 32'(mem_be_o), 32'(4'hF));
                chk("rand/i_adr", 32'(mem_adr_o), 32'(ia[23:2]));
            end
            if (e_iack) chk("rand/ibus_dat", ibus_dat_o, (m_owner == 4) ? m_buf_data : md);
            if (e_dack && !dw) chk("rand/dbus_dat", dbus_dat_o, md);

            if (r) begin
                m_owner  = 0;
                m_dprio  = 1;
                m_buf_ok = 0;
            end else begin
                case (m_owner)
                    0: begin
                        if (dr && (!ir || m_dprio)) begin
                            if (dw && !da[c_RAM_BIT]) begin
                                m_owner = 3;
                            end else begin
                                m_owner = 2;
                                m_dprio = 0;
                            end
                        end else if (ir) begin
`ifdef WB_QSPI_ARB_IBUF_EN
                            if (m_buf_ok && m_buf_word == ia[23:2]) begin
                                m_owner = 4;
                            end else
`endif
                            begin
                                m_owner = 1;
                                m_dprio = 1;
                            end
                        end
                    end
                    1: begin
                        if (mack) begin
                            m_owner = 0;
`ifdef WB_QSPI_ARB_IBUF_EN
                            m_buf_ok   = 1;
                            m_buf_word = ia[23:2];
                            m_buf_data = md;
`endif
                        end
                    end
                    2: begin
                        if (mack) begin
                            m_owner = 0;
                            if (dw && da[c_RAM_BIT] && m_buf_word == da[23:2]) m_buf_ok = 0;
                        end
                    end
                    default: m_owner = 0;
                endcase
            end
            if (e_iack) ir = 0;
            if (e_dack || e_err) dr = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
